bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request conversion; sampled only in IDLE.
REQ-005 tens  input  4  BCD tens digit; captured on accepted start.
REQ-006 ones  input  4  BCD ones digit; captured on accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 valid  output  1  one-cycle pulse marking a completed result.
REQ-009 binary  output  8  unsigned result, range 0..99, zero-extended.
REQ-010 err  output  1  high with valid when a captured digit exceeded 9; held until the next completion.

Function
REQ-011 SHALL implement reverse double-dabble: 16-bit work register {bcd[7:0], bin[7:0]}, with bcd loaded as {tens, ones} and bin loaded as 0.
REQ-012 Each iteration SHALL shift the work register right by 1 and then subtract 3 from each 4-bit BCD digit whose shifted value is >= 8, with exactly 8 iterations.
REQ-013 The FSM states SHALL be IDLE, CONV and DONE, with reset state IDLE.
REQ-014 In IDLE, start=1 at edge k SHALL load the work register, clear the iteration counter and enter CONV; busy=1 from edge k.
REQ-015 CONV SHALL perform one iteration per edge (edges k+1..k+8); after the 8th iteration it SHALL enter DONE; busy=1 throughout CONV.
REQ-016 On entering DONE (edge k+8), binary SHALL register bin[7:0], err SHALL register the digit check, busy SHALL drop to 0, and valid SHALL be 1 for exactly one cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; a new start is accepted from IDLE only, so back-to-back throughput is one result per 10 cycles.
REQ-018 Latency SHALL be fixed: valid is high in the cycle after edge k+8, for every input value.
REQ-019 start asserted while busy=1 or in DONE SHALL be ignored, with no effect on the running conversion or on the captured digits.
REQ-020 Changes on tens and ones after capture SHALL NOT affect the result.
REQ-021 If tens > 9 or ones > 9 at capture, the result SHALL be binary=8'd0 and err=1; the timing is unchanged (valid still pulses at edge k+8).
REQ-022 binary and err SHALL hold their last values between completions; valid=0 outside DONE.
REQ-023 The iteration counter SHALL be 4 bits and saturate-free; CONV exits on count==7 at the iteration edge, with no wrap-around reachable.

Reset
REQ-024 rst_n=0 SHALL force state IDLE, busy=0, valid=0, binary=0, err=0, work register=0, counter=0, asynchronously.
REQ-025 Reset asserted mid-CONV SHALL abort the conversion with no valid pulse; the first start after rst_n rises SHALL be handled normally.
REQ-026 Release of rst_n SHALL be treated as synchronous to clk by the surrounding design; the block needs no internal synchronizer.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/CONV/DONE), ITERATIONS=8, DIGIT_MAX=9 and ADJ_THRESHOLD=8.
REQ-028 One sub-module, bcd_digit_adj (4-bit in, 4-bit out: subtract 3 if >= 8), SHALL be instantiated twice, once per digit.
REQ-029 All outputs SHALL be driven directly from registers.

Verification
REQ-030 tens=4, ones=2, start pulse at edge k -> busy for edges k..k+7, valid pulse after edge k+8, binary=8'h2A, err=0.
REQ-031 tens=9, ones=9 -> binary=8'd99, err=0; tens=0, ones=0 -> binary=8'd0, err=0.
REQ-032 tens=4'hA, ones=3 -> valid at k+8, binary=0, err=1; a following tens=1, ones=5 -> binary=15, err=0.
REQ-033 start=1 held continuously with tens=2, ones=7, with digits changed to 8/8 mid-conversion -> results 27 every 10 cycles, and the mid-conversion digit change is not reflected.
REQ-034 rst_n pulsed low at edge k+4 of a conversion -> no valid pulse, all outputs 0; a new start with 6/1 -> binary=61.
REQ-035 Exhaustive sweep of 00..99 against a reference model -> binary equals 10*tens+ones, and valid occurs exactly once per start.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding and
// the constants of the reverse double-dabble algorithm.
package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITERATIONS    = 8;
  localparam int DIGIT_MAX     = 9;
  localparam int ADJ_THRESHOLD = 8;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble: a BCD digit that
// reaches 8 after the right shift is brought back into range by subtracting 3.
module bcd_digit_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'(ADJ_THRESHOLD)) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Two-digit BCD to 8-bit binary converter using reverse double-dabble,
// one shift/adjust iteration per clock with fixed latency.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       valid,
  output logic [7:0] binary,
  output logic       err
);

  state_t      state;
  state_t      state_next;
  logic [15:0] work;
  logic [15:0] shifted;
  logic [15:0] work_next;
  logic [3:0]  cnt;
  logic [3:0]  tens_adj;
  logic [3:0]  ones_adj;
  logic        digit_bad;
  logic        last_iter;
  logic        shift_out_unused;

  // Work register is {bcd tens, bcd ones, bin}; the bit shifted out is dropped.
  assign shifted          = {1'b0, work[15:1]};
  assign shift_out_unused = work[0];
  assign last_iter        = (cnt == 4'(ITERATIONS - 1));

  bcd_digit_adj u_adj_tens (
    .din  (shifted[15:12]),
    .dout (tens_adj)
  );

  bcd_digit_adj u_adj_ones (
    .din  (shifted[11:8]),
    .dout (ones_adj)
  );

  assign work_next = {tens_adj, ones_adj, shifted[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/valid are registered copies of the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      cnt       <= '0;
      digit_bad <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      binary    <= '0;
      err       <= 1'b0;
    end else begin
      busy  <= (state_next == CONV);
      valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            work      <= {tens, ones, 8'h00};
            cnt       <= '0;
            digit_bad <= (tens > 4'(DIGIT_MAX)) || (ones > 4'(DIGIT_MAX));
          end
        end
        CONV: begin
          work <= work_next;
          cnt  <= cnt + 4'd1;
          if (last_iter) begin
            binary <= digit_bad ? 8'd0 : work_next[7:0];
            err    <= digit_bad;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases, exhaustive 00..99 sweep
// and random digits (including invalid ones) against an arithmetic model.
module tb_bcd_to_bin;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       valid;
  logic [7:0] binary;
  logic       err;

  int checks_done;
  int fail_count;

  bcd_to_bin dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .tens   (tens),
    .ones   (ones),
    .busy   (busy),
    .valid  (valid),
    .binary (binary),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks_done++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: plain decimal arithmetic, invalid digits give 0 with err.
  function automatic logic [8:0] model(input int t, input int o);
    if (t > 9 || o > 9) return {1'b1, 8'd0};
    return {1'b0, 8'(10 * t + o)};
  endfunction

  // Runs one conversion from IDLE; hold keeps start high and scrambles the
  // digits mid-conversion, which must not disturb the captured operands.
  task automatic applyStimulus(input logic [3:0] t, input logic [3:0] o, input bit hold);
    logic [8:0] exp_res;
    logic [7:0] prev_bin;
    exp_res = model(int'(t), int'(o));
    tens  = t;
    ones  = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy_at_k", {7'd0, busy}, 8'd1);
    checkOutput("valid_at_k", {7'd0, valid}, 8'd0);
    start = hold;
    for (int i = 1; i <= 8; i++) begin
      tens = 4'($urandom_range(0, 15));
      ones = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      if (i < 8) begin
        checkOutput("busy_conv", {7'd0, busy}, 8'd1);
        checkOutput("valid_conv", {7'd0, valid}, 8'd0);
      end else begin
        checkOutput("valid_k8", {7'd0, valid}, 8'd1);
        checkOutput("busy_k8", {7'd0, busy}, 8'd0);
        checkOutput("binary", binary, exp_res[7:0]);
        checkOutput("err", {7'd0, err}, {7'd0, exp_res[8]});
      end
    end
    prev_bin = exp_res[7:0];
    @(posedge clk);
    #1;
    checkOutput("valid_k9", {7'd0, valid}, 8'd0);
    checkOutput("busy_k9", {7'd0, busy}, 8'd0);
    checkOutput("binary_hold", binary, prev_bin);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] last_bin;
    checks_done = 0;
    fail_count  = 0;
    start = 1'b0;
    tens  = 4'd0;
    ones  = 4'd0;
    rst_n = 1'b0;
    #12;
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_valid", {7'd0, valid}, 8'd0);
    checkOutput("rst_binary", binary, 8'd0);
    checkOutput("rst_err", {7'd0, err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(4'd4, 4'd2, 1'b0);
    applyStimulus(4'd9, 4'd9, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b0);
    applyStimulus(4'hA, 4'd3, 1'b0);
    applyStimulus(4'd1, 4'd5, 1'b0);
    applyStimulus(4'd2, 4'd7, 1'b1);
    applyStimulus(4'd2, 4'd7, 1'b1);
    applyStimulus(4'd2, 4'd7, 1'b1);

    // Abort mid-conversion: no valid may appear and outputs must clear.
    tens  = 4'd2;
    ones  = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {7'd0, busy}, 8'd0);
    checkOutput("abort_valid", {7'd0, valid}, 8'd0);
    checkOutput("abort_binary", binary, 8'd0);
    checkOutput("abort_err", {7'd0, err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_valid", {7'd0, valid}, 8'd0);
    end
    applyStimulus(4'd6, 4'd1, 1'b0);

    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++)
        applyStimulus(4'(t), 4'(o), 1'($urandom_range(0, 1)));

    for (int n = 0; n < 60; n++)
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    last_bin = binary;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_valid", {7'd0, valid}, 8'd0);
      checkOutput("idle_hold", binary, last_bin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
